// File: rtl/ahfp_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
// Holds operand width, adder latency, the result-routing tag and FP constants.
package ahfp_pkg;

    localparam int FP_W     = 32;
    localparam int ADD_LAT  = 7;
    localparam int MAX_NREQ = 8;
    localparam int ID_W     = $clog2(MAX_NREQ);

    localparam logic [31:0] FP_ONE = 32'h3F800000;
    localparam logic [31:0] FP_TWO = 32'h40000000;

    // One entry of the tag pipeline: which requester owns the op in that stage.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/ahfp_add_arbiter_rr.sv
// Combinational round-robin picker.
// Ports: req (request vector), last (previous winner) -> grant (one-hot), idx, any.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        // Scan starting just after the previous winner, wrapping around.
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahfp_add_arbiter.sv
// Shares one pipelined FP adder among NREQ requesters with round-robin grants.
// Ports: clk, reset_n, hold, req_* (requests), rsp_* (results), add_* (adder side), in_flight, idle.
module ahfp_add_arbiter
    import ahfp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = ADD_LAT,
    parameter int FP_W = ahfp_pkg::FP_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*FP_W-1:0]   req_dataa,
    input  logic [NREQ*FP_W-1:0]   req_datab,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [FP_W-1:0]        rsp_result,
    output logic [FP_W-1:0]        add_dataa,
    output logic [FP_W-1:0]        add_datab,
    input  logic [FP_W-1:0]        add_result,
    output logic [$clog2(LAT+2)-1:0] in_flight,
    output logic                   idle
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT + 2);

    logic [IW-1:0]   last;
    logic [IW-1:0]   grant_idx;
    logic            accept;
    logic [FP_W-1:0] sel_a;
    logic [FP_W-1:0] sel_b;
    tag_t            tags [LAT+1];
    tag_t            tag_out;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req_valid & {NREQ{~hold}}),
        .last  (last),
        .grant (req_ready),
        .idx   (grant_idx),
        .any   (accept)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_a = req_dataa[i*FP_W +: FP_W];
                sel_b = req_datab[i*FP_W +: FP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            add_dataa <= '0;
            add_datab <= '0;
            last      <= IW'(NREQ - 1);
        end else if (accept) begin
            add_dataa <= sel_a;
            add_datab <= sel_b;
            last      <= grant_idx;
        end
    end

    // Tag stage LAT lines up with add_result; it never stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= LAT; k++) begin
                tags[k] <= '0;
            end
        end else begin
            tags[0].valid <= accept;
            tags[0].id    <= ID_W'(grant_idx);
            for (int k = 1; k <= LAT; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign tag_out = tags[LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_flight <= '0;
        end else if (accept && !tag_out.valid) begin
            in_flight <= in_flight + CW'(1);
        end else if (!accept && tag_out.valid) begin
            in_flight <= in_flight - CW'(1);
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_out.valid && (tag_out.id == ID_W'(i));
        end
    end

    assign rsp_result = add_result;
    assign idle       = (in_flight == '0) && !(|req_valid);

endmodule

// File: tb/tb_ahfp_add_arbiter.sv
// Bench for ahfp_add_arbiter with a behavioural 7-stage adder.
// Grant table under reset, then scoreboarded scenarios and hand-checked corners.
module tb_ahfp_add_arbiter;
    import ahfp_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 7;

    logic                 clk;
    logic                 reset_n;
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_dataa;
    logic [NREQ*32-1:0]   req_datab;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_result;
    logic [31:0]          add_dataa;
    logic [31:0]          add_datab;
    logic [31:0]          add_result;
    logic [3:0]           in_flight;
    logic                 idle;

    logic [31:0] da [NREQ];
    logic [31:0] db [NREQ];
    logic [31:0] apipe [LAT];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } exp_t;
    exp_t q[$];
    int   m_last = NREQ - 1;

    typedef struct {
        logic            hold;
        logic [NREQ-1:0] rv;
        logic [NREQ-1:0] ready;
        logic            idle;
    } vec_t;
    vec_t vecs [9];

    ahfp_add_arbiter #(
        .NREQ (NREQ),
        .LAT  (LAT),
        .FP_W (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .add_dataa  (add_dataa),
        .add_datab  (add_datab),
        .add_result (add_result),
        .in_flight  (in_flight),
        .idle       (idle)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_dataa[i*32 +: 32] = da[i];
            req_datab[i*32 +: 32] = db[i];
        end
    end

    // Positive normal single-precision add, truncating.
    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        logic [7:0]  ea, eb, e;
        logic [24:0] ma, mb, s;
        logic [31:0] t;
        if (a[30:23] < b[30:23]) begin
            t = a; a = b; b = t;
        end
        ea = a[30:23];
        eb = b[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        mb = (ea - eb > 8'd24) ? 25'd0 : (mb >> (ea - eb));
        s  = ma + mb;
        if (s[24]) begin
            e = ea + 8'd1;
            return {1'b0, e, s[23:1]};
        end
        return {1'b0, ea, s[22:0]};
    endfunction

    always @(posedge clk) begin
        apipe[0] <= fadd(add_dataa, add_datab);
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_result = apipe[LAT-1];

    function automatic logic [NREQ-1:0] model_grant(logic h,
                                                    logic [NREQ-1:0] rv,
                                                    int lst);
        int j;
        if (h) return '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (lst + k) % NREQ;
            if (rv[j]) return NREQ'(1) << j;
        end
        return '0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: predict grants, push expected results, pop on response.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        exp_t e;
        int id;
        if (mon_on) begin
            if (!reset_n) begin
                q.delete();
                m_last = NREQ - 1;
                chk("rst_rsp", 32'(rsp_valid), 32'd0);
                chk("rst_inflight", 32'(in_flight), 32'd0);
            end else begin
                chk("sb_inflight", 32'(in_flight), 32'(q.size()));
                chk("sb_idle", 32'(idle), 32'((q.size() == 0) && (req_valid == 0)));
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("sb_rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.id));
                    chk("sb_rsp_result", rsp_result, e.res);
                end else begin
                    chk("sb_no_rsp", 32'(rsp_valid), 32'd0);
                end
                eg = model_grant(hold, req_valid, m_last);
                chk("sb_grant", 32'(req_ready), 32'(eg));
                if (eg != 0) begin
                    id = 0;
                    for (int i = 0; i < NREQ; i++) if (eg[i]) id = i;
                    e.id  = id;
                    e.res = fadd(da[id], db[id]);
                    e.due = cyc + LAT + 1;
                    q.push_back(e);
                    m_last = id;
                end
            end
        end
    end

    task automatic wait_idle(string name);
        int n = 0;
        while (!idle && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(idle), 32'd1);
    endtask

    task automatic drive(logic h, logic [NREQ-1:0] rv);
        @(posedge clk);
        #1;
        hold      = h;
        req_valid = rv;
    endtask

    initial begin
        int n, acc, cnt, first, lastc, mx;
        reset_n   = 0;
        hold      = 0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            da[i] = '0;
            db[i] = '0;
        end

        vecs[0] = '{1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[1] = '{1'b0, 4'b0001, 4'b0001, 1'b0};
        vecs[2] = '{1'b0, 4'b0110, 4'b0010, 1'b0};
        vecs[3] = '{1'b0, 4'b1000, 4'b1000, 1'b0};
        vecs[4] = '{1'b0, 4'b1100, 4'b0100, 1'b0};
        vecs[5] = '{1'b0, 4'b1111, 4'b0001, 1'b0};
        vecs[6] = '{1'b1, 4'b1111, 4'b0000, 1'b0};
        vecs[7] = '{1'b1, 4'b0010, 4'b0000, 1'b0};
        vecs[8] = '{1'b0, 4'b1010, 4'b0010, 1'b0};

        // Grant function while held in reset: pointer sits at NREQ-1.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_add_a", add_dataa, 32'd0);
        chk("reset_add_b", add_datab, 32'd0);
        chk("reset_rsp", 32'(rsp_valid), 32'd0);
        chk("reset_inflight", 32'(in_flight), 32'd0);
        for (int v = 0; v < 9; v++) begin
            hold      = vecs[v].hold;
            req_valid = vecs[v].rv;
            #1;
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].ready));
            chk($sformatf("vec%0d_idle", v), 32'(idle), 32'(vecs[v].idle));
        end
        hold      = 0;
        req_valid = '0;
        mon_on    = 1;
        @(posedge clk);
        #1;
        reset_n = 1;

        // 1 + 1 from requester 0.
        @(posedge clk);
        #1;
        da[0] = FP_ONE;
        db[0] = FP_ONE;
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("t1_if0", 32'(in_flight), 32'd0);
        acc = cyc;
        drive(0, 4'b0000);
        @(negedge clk);
        chk("t1_if1", 32'(in_flight), 32'd1);
        n = 0;
        while (rsp_valid == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_latency", 32'(cyc - acc), 32'd8);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_result", rsp_result, FP_TWO);
        @(negedge clk);
        chk("t1_if_end", 32'(in_flight), 32'd0);

        // All four requesters streaming 1.5 + 1.
        for (int i = 0; i < NREQ; i++) begin
            da[i] = 32'h3FC00000;
            db[i] = FP_ONE;
        end
        mx = 0;
        for (int k = 0; k < 16; k++) begin
            drive(0, 4'b1111);
            @(negedge clk);
            if (int'(in_flight) > mx) mx = int'(in_flight);
            if (rsp_valid != 0) chk("t2_result", rsp_result, 32'h40200000);
        end
        chk("t2_inflight_max", 32'(mx), 32'd8);
        drive(0, 4'b0000);
        wait_idle("t2_drain");

        // Requester 2 alone, back to back: 3 + 1.
        da[2] = 32'h40400000;
        db[2] = FP_ONE;
        cnt = 0; first = -1; lastc = -1;
        for (int k = 0; k < 25; k++) begin
            drive(0, (k < 10) ? 4'b0100 : 4'b0000);
            @(negedge clk);
            if (rsp_valid == 4'b0100) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                cnt++;
                chk("t3_result", rsp_result, 32'h40800000);
            end
        end
        chk("t3_count", 32'(cnt), 32'd10);
        chk("t3_span", 32'(lastc - first), 32'd9);
        wait_idle("t3_drain");

        // Hold with ops in flight: no grants, results still return.
        for (int i = 0; i < NREQ; i++) begin
            da[i] = 32'h3F800000 + (32'(i) << 23);
            db[i] = FP_ONE;
        end
        for (int k = 0; k < 3; k++) drive(0, 4'b1111);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1, 4'b1010);
            #1;
            chk("t4_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            if (rsp_valid != 0) cnt++;
        end
        chk("t4_returned", 32'(cnt), 32'd3);
        @(posedge clk);
        #1;
        reset_n = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        drive(0, 4'b1010);
        #1;
        chk("t4_after_hold", 32'(req_ready), 32'h2);
        drive(0, 4'b0000);
        wait_idle("t4_drain");

        // Reset while three ops are in the pipe.
        for (int k = 0; k < 3; k++) drive(0, 4'b0001);
        drive(0, 4'b0000);
        @(posedge clk);
        #1;
        reset_n = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) cnt++;
        end
        chk("t5_no_rsp", 32'(cnt), 32'd0);
        chk("t5_inflight", 32'(in_flight), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);

        // Requester 1 withdraws while requester 0 wins.
        drive(0, 4'b0011);
        #1;
        chk("t6_ready", 32'(req_ready), 32'h1);
        drive(0, 4'b0000);
        cnt = 0; n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid[1]) cnt++;
            if (rsp_valid[0]) n++;
        end
        chk("t6_no_rsp1", 32'(cnt), 32'd0);
        chk("t6_rsp0", 32'(n), 32'd1);

        // Random traffic with distinct operands per requester.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 9) == 0), NREQ'($urandom));
        end
        drive(0, 4'b0000);
        wait_idle("rand_drain");

        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
